// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - opcode latch, T-state counter and interrupt injection
module instruction_sequencer #(
    parameter int              DATA_W     = 8,
    parameter int              CYCLE_W    = 3,
    parameter int              MAX_CYCLE  = 7,
    parameter logic [DATA_W-1:0] INT_OPCODE = 8'h00
) (
    input  logic               sys_clock,
    input  logic               rst,
    input  logic               clk_phase_1,
    input  logic [DATA_W-1:0]  PD_register,
    input  logic               increment_cycle_counter,
    input  logic               reset_cycle_counter,
    input  logic               skip_cycle_counter,
    input  logic               nmi_req,
    input  logic               irq_req,
    input  logic               irq_mask,
    output logic [DATA_W-1:0]  IR_register,
    output logic [CYCLE_W-1:0] cycle,
    output logic [CYCLE_W-1:0] next_cycle,
    output logic               sync,
    output logic               interrupt_pending,
    output logic [1:0]         int_source,
    output logic               cycle_overrun
);

    localparam logic [1:0] SRC_OPCODE = 2'b00;
    localparam logic [1:0] SRC_IRQ    = 2'b01;
    localparam logic [1:0] SRC_NMI    = 2'b10;
    localparam logic [1:0] SRC_RESET  = 2'b11;

    localparam logic [CYCLE_W:0]   MAX_EXT   = (CYCLE_W+1)'(MAX_CYCLE);
    localparam logic [CYCLE_W-1:0] MAX_SHORT = CYCLE_W'(MAX_CYCLE);

    logic [DATA_W-1:0]  ir_q, ir_d;
    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic [1:0]         src_q, src_d;
    logic               overrun_q, overrun_d;
    logic               nmi_prev_q, nmi_prev_d;
    logic               nmi_latched_q, nmi_latched_d;

    logic [CYCLE_W:0]   step;
    logic [CYCLE_W:0]   sum;
    logic               overrun_attempt;
    logic               irq_active;
    logic               nmi_edge;

    // Counter arithmetic: widened sum so a step past MAX_CYCLE is detected, then clamped
    always_comb begin
        step = '0;
        if (skip_cycle_counter) begin
            step = (CYCLE_W+1)'(2);
        end else if (increment_cycle_counter) begin
            step = (CYCLE_W+1)'(1);
        end
        sum             = {1'b0, cycle_q} + step;
        overrun_attempt = !reset_cycle_counter && (sum > MAX_EXT);
        if (reset_cycle_counter) begin
            next_cycle = '0;
        end else if (overrun_attempt) begin
            next_cycle = MAX_SHORT;
        end else begin
            next_cycle = sum[CYCLE_W-1:0];
        end
    end

    assign irq_active        = irq_req & ~irq_mask;
    assign nmi_edge          = nmi_req & ~nmi_prev_q;
    assign interrupt_pending = nmi_latched_q | irq_active;
    assign sync              = (cycle_q == '0);
    assign IR_register       = ir_q;
    assign cycle             = cycle_q;
    assign int_source        = src_q;
    assign cycle_overrun     = overrun_q;

    // Next-state: everything advances only on phase-1; boundaries pick NMI, then IRQ, then opcode
    always_comb begin
        ir_d          = ir_q;
        cycle_d       = cycle_q;
        src_d         = src_q;
        overrun_d     = overrun_q;
        nmi_prev_d    = nmi_prev_q;
        nmi_latched_d = nmi_latched_q;
        if (clk_phase_1) begin
            cycle_d       = next_cycle;
            overrun_d     = overrun_q | overrun_attempt;
            nmi_prev_d    = nmi_req;
            nmi_latched_d = nmi_latched_q | nmi_edge;
            if (reset_cycle_counter) begin
                if (nmi_latched_q) begin
                    // A fresh edge on the same edge the old one is taken stays pending
                    ir_d          = INT_OPCODE;
                    src_d         = SRC_NMI;
                    nmi_latched_d = nmi_edge;
                end else if (irq_active) begin
                    ir_d  = INT_OPCODE;
                    src_d = SRC_IRQ;
                end else begin
                    ir_d  = PD_register;
                    src_d = SRC_OPCODE;
                end
            end
        end
    end

    // State registers; reset injects the interrupt opcode regardless of phase
    always_ff @(posedge sys_clock) begin
        if (!rst) begin
            ir_q          <= INT_OPCODE;
            cycle_q       <= '0;
            src_q         <= SRC_RESET;
            overrun_q     <= 1'b0;
            nmi_prev_q    <= 1'b0;
            nmi_latched_q <= 1'b0;
        end else begin
            ir_q          <= ir_d;
            cycle_q       <= cycle_d;
            src_q         <= src_d;
            overrun_q     <= overrun_d;
            nmi_prev_q    <= nmi_prev_d;
            nmi_latched_q <= nmi_latched_d;
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - directed bench for instruction_sequencer
module tb_instruction_sequencer;

    logic       sys_clock = 1'b0;
    logic       rst = 1'b0;
    logic       clk_phase_1 = 1'b1;
    logic [7:0] PD_register = 8'h00;
    logic       increment_cycle_counter = 1'b0;
    logic       reset_cycle_counter = 1'b0;
    logic       skip_cycle_counter = 1'b0;
    logic       nmi_req = 1'b0;
    logic       irq_req = 1'b0;
    logic       irq_mask = 1'b1;
    logic [7:0] IR_register;
    logic [2:0] cycle;
    logic [2:0] next_cycle;
    logic       sync;
    logic       interrupt_pending;
    logic [1:0] int_source;
    logic       cycle_overrun;

    int vectors = 0;
    int miscompares = 0;

    instruction_sequencer dut (
        .sys_clock               (sys_clock),
        .rst                     (rst),
        .clk_phase_1             (clk_phase_1),
        .PD_register             (PD_register),
        .increment_cycle_counter (increment_cycle_counter),
        .reset_cycle_counter     (reset_cycle_counter),
        .skip_cycle_counter      (skip_cycle_counter),
        .nmi_req                 (nmi_req),
        .irq_req                 (irq_req),
        .irq_mask                (irq_mask),
        .IR_register             (IR_register),
        .cycle                   (cycle),
        .next_cycle              (next_cycle),
        .sync                    (sync),
        .interrupt_pending       (interrupt_pending),
        .int_source              (int_source),
        .cycle_overrun           (cycle_overrun)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic tick();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic boundary(input logic [7:0] pd);
        PD_register = pd;
        reset_cycle_counter = 1'b1;
        tick();
        reset_cycle_counter = 1'b0;
    endtask

    task automatic test_reset();
        PD_register = 8'hCC;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        vectors++; if (IR_register !== 8'h00) begin miscompares++; $display("FAIL reset_ir got %h want 00", IR_register); end
        vectors++; if (cycle !== 3'd0) begin miscompares++; $display("FAIL reset_cycle got %0d want 0", cycle); end
        vectors++; if (int_source !== 2'b11) begin miscompares++; $display("FAIL reset_src got %b want 11", int_source); end
        vectors++; if (sync !== 1'b1) begin miscompares++; $display("FAIL reset_sync got %b want 1", sync); end
        vectors++; if (cycle_overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", cycle_overrun); end
        vectors++; if (interrupt_pending !== 1'b0) begin miscompares++; $display("FAIL reset_pending got %b want 0", interrupt_pending); end
    endtask

    task automatic test_count();
        boundary(8'hCC);
        vectors++; if (IR_register !== 8'hCC) begin miscompares++; $display("FAIL count_ir got %h want cc", IR_register); end
        vectors++; if (int_source !== 2'b00) begin miscompares++; $display("FAIL count_src got %b want 00", int_source); end
        increment_cycle_counter = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        increment_cycle_counter = 1'b0;
        #1;
        vectors++; if (cycle !== 3'd3) begin miscompares++; $display("FAIL count_cycle got %0d want 3", cycle); end
        vectors++; if (next_cycle !== 3'd3) begin miscompares++; $display("FAIL count_next got %0d want 3", next_cycle); end
        vectors++; if (sync !== 1'b0) begin miscompares++; $display("FAIL count_sync got %b want 0", sync); end
        vectors++; if (IR_register !== 8'hCC) begin miscompares++; $display("FAIL count_ir_held got %h want cc", IR_register); end
    endtask

    task automatic test_overrun();
        skip_cycle_counter = 1'b1;
        #1;
        vectors++; if (next_cycle !== 3'd5) begin miscompares++; $display("FAIL skip_next got %0d want 5", next_cycle); end
        tick();
        skip_cycle_counter = 1'b0;
        increment_cycle_counter = 1'b1;
        tick();
        increment_cycle_counter = 1'b0;
        vectors++; if (cycle !== 3'd6) begin miscompares++; $display("FAIL ovr_cycle6 got %0d want 6", cycle); end
        vectors++; if (cycle_overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_early got %b want 0", cycle_overrun); end
        skip_cycle_counter = 1'b1;
        #1;
        vectors++; if (next_cycle !== 3'd7) begin miscompares++; $display("FAIL ovr_next got %0d want 7", next_cycle); end
        tick();
        skip_cycle_counter = 1'b0;
        vectors++; if (cycle !== 3'd7) begin miscompares++; $display("FAIL ovr_cycle got %0d want 7", cycle); end
        vectors++; if (cycle_overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag got %b want 1", cycle_overrun); end
        boundary(8'hCC);
        vectors++; if (cycle !== 3'd0) begin miscompares++; $display("FAIL ovr_bound_cycle got %0d want 0", cycle); end
        vectors++; if (cycle_overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky got %b want 1", cycle_overrun); end
    endtask

    task automatic test_nmi();
        increment_cycle_counter = 1'b1;
        tick(); tick();
        increment_cycle_counter = 1'b0;
        nmi_req = 1'b1;
        tick();
        vectors++; if (cycle !== 3'd2) begin miscompares++; $display("FAIL nmi_cycle got %0d want 2", cycle); end
        vectors++; if (interrupt_pending !== 1'b1) begin miscompares++; $display("FAIL nmi_pending got %b want 1", interrupt_pending); end
        boundary(8'hA9);
        vectors++; if (IR_register !== 8'h00) begin miscompares++; $display("FAIL nmi_ir got %h want 00", IR_register); end
        vectors++; if (int_source !== 2'b10) begin miscompares++; $display("FAIL nmi_src got %b want 10", int_source); end
        vectors++; if (interrupt_pending !== 1'b0) begin miscompares++; $display("FAIL nmi_cleared got %b want 0", interrupt_pending); end
        tick();
        boundary(8'hA9);
        vectors++; if (IR_register !== 8'hA9) begin miscompares++; $display("FAIL nmi_held_ir got %h want a9", IR_register); end
        vectors++; if (int_source !== 2'b00) begin miscompares++; $display("FAIL nmi_held_src got %b want 00", int_source); end
        nmi_req = 1'b0;
        tick();
        // edge coinciding with a boundary: opcode first, NMI at the following boundary
        nmi_req = 1'b1;
        boundary(8'h55);
        vectors++; if (IR_register !== 8'h55) begin miscompares++; $display("FAIL nmi_same_ir got %h want 55", IR_register); end
        vectors++; if (interrupt_pending !== 1'b1) begin miscompares++; $display("FAIL nmi_same_pending got %b want 1", interrupt_pending); end
        boundary(8'h55);
        vectors++; if (int_source !== 2'b10) begin miscompares++; $display("FAIL nmi_deferred_src got %b want 10", int_source); end
        nmi_req = 1'b0;
        tick();
    endtask

    task automatic test_irq();
        irq_req = 1'b1;
        irq_mask = 1'b1;
        boundary(8'h5A);
        vectors++; if (IR_register !== 8'h5A) begin miscompares++; $display("FAIL irq_masked_ir got %h want 5a", IR_register); end
        vectors++; if (int_source !== 2'b00) begin miscompares++; $display("FAIL irq_masked_src got %b want 00", int_source); end
        irq_mask = 1'b0;
        #1;
        vectors++; if (interrupt_pending !== 1'b1) begin miscompares++; $display("FAIL irq_pending got %b want 1", interrupt_pending); end
        boundary(8'h5A);
        vectors++; if (IR_register !== 8'h00) begin miscompares++; $display("FAIL irq_ir got %h want 00", IR_register); end
        vectors++; if (int_source !== 2'b01) begin miscompares++; $display("FAIL irq_src got %b want 01", int_source); end
        nmi_req = 1'b1;
        tick();
        boundary(8'h5A);
        vectors++; if (int_source !== 2'b10) begin miscompares++; $display("FAIL irq_nmi_prio got %b want 10", int_source); end
        boundary(8'h5A);
        vectors++; if (int_source !== 2'b01) begin miscompares++; $display("FAIL irq_after_nmi got %b want 01", int_source); end
        irq_req = 1'b0;
        nmi_req = 1'b0;
        boundary(8'h3C);
        vectors++; if (IR_register !== 8'h3C) begin miscompares++; $display("FAIL irq_lost_ir got %h want 3c", IR_register); end
        vectors++; if (int_source !== 2'b00) begin miscompares++; $display("FAIL irq_lost_src got %b want 00", int_source); end
    endtask

    task automatic test_phase();
        increment_cycle_counter = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        vectors++; if (cycle !== 3'd4) begin miscompares++; $display("FAIL phase_start got %0d want 4", cycle); end
        clk_phase_1 = 1'b0;
        reset_cycle_counter = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        vectors++; if (IR_register !== 8'h3C) begin miscompares++; $display("FAIL phase_ir got %h want 3c", IR_register); end
        reset_cycle_counter = 1'b0;
        #1;
        vectors++; if (cycle !== 3'd4) begin miscompares++; $display("FAIL phase_hold got %0d want 4", cycle); end
        vectors++; if (next_cycle !== 3'd5) begin miscompares++; $display("FAIL phase_next got %0d want 5", next_cycle); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        increment_cycle_counter = 1'b0;
        vectors++; if (cycle !== 3'd0) begin miscompares++; $display("FAIL phase_rst_cycle got %0d want 0", cycle); end
        vectors++; if (int_source !== 2'b11) begin miscompares++; $display("FAIL phase_rst_src got %b want 11", int_source); end
        vectors++; if (cycle_overrun !== 1'b0) begin miscompares++; $display("FAIL phase_rst_ovr got %b want 0", cycle_overrun); end
        clk_phase_1 = 1'b1;
    endtask

    initial begin
        test_reset();
        test_count();
        test_overrun();
        test_nmi();
        test_irq();
        test_phase();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
